// File: rtl/trakball_decoder.sv
// Trackball step-stream receiver: per-axis synchronised direction/clock pairs
// drive wrapping up/down counters, with a hold-able CPU-visible snapshot.
module trakball_decoder #(
    parameter int CNT_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic [3:0]       trak_i,
    input  logic             flip_i,
    input  logic             clr_i,
    input  logic             hold_i,
    output logic [CNT_W-1:0] x_cnt_o,
    output logic [CNT_W-1:0] y_cnt_o,
    output logic             x_dir_o,
    output logic             y_dir_o,
    output logic             x_step_o,
    output logic             y_step_o
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    // Stage 0 sits in the low nibble; the oldest stage is the top nibble.
    logic [SYNC_STAGES*4-1:0] sync_q;
    logic [3:0]               trak_s;

    logic             x_prev, y_prev;
    logic             x_edge, y_edge;
    logic             x_up, y_up;
    logic [CNT_W-1:0] x_live, y_live;
    logic             x_live_dir, y_live_dir;

    assign trak_s = sync_q[SYNC_STAGES*4-1 -: 4];

    assign x_edge = trak_s[2] ^ x_prev;
    assign y_edge = trak_s[0] ^ y_prev;
    assign x_up   = trak_s[3] ^ flip_i;
    assign y_up   = trak_s[1] ^ flip_i;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            x_prev <= 1'b0;
            y_prev <= 1'b0;
        end else begin
            if (SYNC_STAGES > 1)
                sync_q <= {sync_q[SYNC_STAGES*4-5:0], trak_i};
            else
                sync_q <= trak_i;
            x_prev <= trak_s[2];
            y_prev <= trak_s[0];
        end
    end

    // A clear wins over a coincident step: the step is dropped entirely.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            x_live     <= '0;
            y_live     <= '0;
            x_live_dir <= 1'b0;
            y_live_dir <= 1'b0;
            x_step_o   <= 1'b0;
            y_step_o   <= 1'b0;
        end else if (clr_i) begin
            x_live   <= '0;
            y_live   <= '0;
            x_step_o <= 1'b0;
            y_step_o <= 1'b0;
        end else begin
            x_step_o <= x_edge;
            y_step_o <= y_edge;
            if (x_edge) begin
                x_live     <= x_up ? (x_live + ONE) : (x_live - ONE);
                x_live_dir <= x_up;
            end
            if (y_edge) begin
                y_live     <= y_up ? (y_live + ONE) : (y_live - ONE);
                y_live_dir <= y_up;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            x_cnt_o <= '0;
            y_cnt_o <= '0;
            x_dir_o <= 1'b0;
            y_dir_o <= 1'b0;
        end else if (!hold_i) begin
            x_cnt_o <= x_live;
            y_cnt_o <= y_live;
            x_dir_o <= x_live_dir;
            y_dir_o <= y_live_dir;
        end
    end

endmodule

// File: tb/tb_trakball_decoder.sv
// Self-checking bench for trakball_decoder: directed scenarios plus random
// streams compared against a delay-line / modular-arithmetic reference model.
module tb_trakball_decoder;

    localparam int CNT_W       = 4;
    localparam int SYNC_STAGES = 2;
    localparam int MOD         = 1 << CNT_W;
    localparam int D           = SYNC_STAGES;
    localparam int VW          = 2 * CNT_W + 4;

    logic             clk_sys = 1'b0;
    logic             reset   = 1'b1;
    logic [3:0]       trak_i  = '0;
    logic             flip_i  = 1'b0;
    logic             clr_i   = 1'b0;
    logic             hold_i  = 1'b0;
    logic [CNT_W-1:0] x_cnt_o, y_cnt_o;
    logic             x_dir_o, y_dir_o, x_step_o, y_step_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_sys = ~clk_sys;

    trakball_decoder #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .trak_i  (trak_i),
        .flip_i  (flip_i),
        .clr_i   (clr_i),
        .hold_i  (hold_i),
        .x_cnt_o (x_cnt_o),
        .y_cnt_o (y_cnt_o),
        .x_dir_o (x_dir_o),
        .y_dir_o (y_dir_o),
        .x_step_o(x_step_o),
        .y_step_o(y_step_o)
    );

    // Reference model: hist[i] is the trak_i sample taken i+1 edges ago.
    // A step seen at edge n comes from samples n-D and n-D-1.
    logic [3:0] hist [0:D];
    int m_live_x, m_live_y, m_snap_x, m_snap_y;
    logic m_ldir_x, m_ldir_y, m_dir_x, m_dir_y, m_pulse_x, m_pulse_y;
    logic m_edge_x, m_edge_y, m_up_x, m_up_y;

    assign m_edge_x = hist[D-1][2] != hist[D][2];
    assign m_edge_y = hist[D-1][0] != hist[D][0];
    assign m_up_x   = hist[D-1][3] ^ flip_i;
    assign m_up_y   = hist[D-1][1] ^ flip_i;

    always @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= D; i++) hist[i] <= '0;
            m_live_x <= 0; m_live_y <= 0; m_snap_x <= 0; m_snap_y <= 0;
            m_ldir_x <= 0; m_ldir_y <= 0; m_dir_x <= 0; m_dir_y <= 0;
            m_pulse_x <= 0; m_pulse_y <= 0;
        end else begin
            for (int i = 1; i <= D; i++) hist[i] <= hist[i-1];
            hist[0] <= trak_i;
            if (!hold_i) begin
                m_snap_x <= m_live_x; m_snap_y <= m_live_y;
                m_dir_x  <= m_ldir_x; m_dir_y  <= m_ldir_y;
            end
            if (clr_i) begin
                m_live_x <= 0; m_live_y <= 0;
                m_pulse_x <= 0; m_pulse_y <= 0;
            end else begin
                m_pulse_x <= m_edge_x;
                m_pulse_y <= m_edge_y;
                if (m_edge_x) begin
                    m_live_x <= (m_live_x + (m_up_x ? 1 : MOD - 1)) % MOD;
                    m_ldir_x <= m_up_x;
                end
                if (m_edge_y) begin
                    m_live_y <= (m_live_y + (m_up_y ? 1 : MOD - 1)) % MOD;
                    m_ldir_y <= m_up_y;
                end
            end
        end
    end

    logic [VW-1:0] obs;
    assign obs = {x_cnt_o, y_cnt_o, x_dir_o, y_dir_o, x_step_o, y_step_o};

    function automatic logic [VW-1:0] expv();
        logic [CNT_W-1:0] sx, sy;
        sx = m_snap_x[CNT_W-1:0];
        sy = m_snap_y[CNT_W-1:0];
        return {sx, sy, m_dir_x, m_dir_y, m_pulse_x, m_pulse_y};
    endfunction

    task automatic apply_reset();
        @(negedge clk_sys);
        reset  = 1'b1;
        trak_i = '0; flip_i = 0; clr_i = 0; hold_i = 0;
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_sys);
            checks++;
            if (obs !== '0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: got %h want 0", c, obs);
            end
        end
    endtask

    task automatic test_x_up();
        int pulses = 0;
        apply_reset();
        trak_i[3] = 1'b1;
        @(negedge clk_sys);
        for (int t = 0; t < 5; t++) begin
            trak_i[2] = ~trak_i[2];
            for (int j = 1; j <= 4; j++) begin
                @(negedge clk_sys);
                pulses += int'(x_step_o);
                if (t == 0) begin
                    checks++;
                    if (x_cnt_o !== ((j < 4) ? CNT_W'(0) : CNT_W'(1))) begin
                        errors++;
                        $display("FAIL x_latency j=%0d: got %0d", j, x_cnt_o);
                    end
                end
                checks++;
                if (obs !== expv()) begin
                    errors++;
                    $display("FAIL x_up_model: got %h want %h", obs, expv());
                end
            end
        end
        repeat (6) begin
            @(negedge clk_sys);
            pulses += int'(x_step_o);
        end
        checks++;
        if (x_cnt_o !== CNT_W'(5) || x_dir_o !== 1'b1 || y_cnt_o !== '0) begin
            errors++;
            $display("FAIL x_up_final: x=%0d dir=%b y=%0d want 5 1 0", x_cnt_o, x_dir_o, y_cnt_o);
        end
        checks++;
        if (pulses != 5) begin
            errors++;
            $display("FAIL x_up_pulses: got %0d want 5", pulses);
        end
    endtask

    task automatic test_y_wrap();
        apply_reset();
        for (int phase = 0; phase < 2; phase++) begin
            trak_i[1] = (phase == 1);
            @(negedge clk_sys);
            for (int t = 0; t < 3 + phase; t++) begin
                trak_i[0] = ~trak_i[0];
                repeat (2) @(negedge clk_sys);
            end
            repeat (5) @(negedge clk_sys);
            checks++;
            if (y_cnt_o !== ((phase == 0) ? CNT_W'(13) : CNT_W'(1)) || y_dir_o !== phase[0]) begin
                errors++;
                $display("FAIL y_wrap phase %0d: y=%0d dir=%b", phase, y_cnt_o, y_dir_o);
            end
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL y_wrap_model: got %h want %h", obs, expv());
            end
        end
    endtask

    task automatic test_flip_dual();
        apply_reset();
        flip_i = 1'b1;
        trak_i = 4'b1010;
        @(negedge clk_sys);
        repeat (2) begin
            trak_i[2] = ~trak_i[2];
            repeat (2) @(negedge clk_sys);
        end
        repeat (5) @(negedge clk_sys);
        checks++;
        if (x_cnt_o !== CNT_W'(14) || x_dir_o !== 1'b0) begin
            errors++;
            $display("FAIL flip_x: x=%0d dir=%b want 14 0", x_cnt_o, x_dir_o);
        end
        trak_i[2] = ~trak_i[2];
        trak_i[0] = ~trak_i[0];
        repeat (3) @(negedge clk_sys);
        checks++;
        if (x_step_o !== 1'b1 || y_step_o !== 1'b1) begin
            errors++;
            $display("FAIL dual_pulse: x_step=%b y_step=%b want 1 1", x_step_o, y_step_o);
        end
        @(negedge clk_sys);
        checks++;
        if (x_cnt_o !== CNT_W'(13) || y_cnt_o !== CNT_W'(15)) begin
            errors++;
            $display("FAIL dual_step: x=%0d y=%0d want 13 15", x_cnt_o, y_cnt_o);
        end
    endtask

    task automatic test_hold_clr();
        logic hold_bad = 1'b0;
        apply_reset();
        trak_i[3] = 1'b1;
        @(negedge clk_sys);
        repeat (2) begin
            trak_i[2] = ~trak_i[2];
            @(negedge clk_sys);
        end
        repeat (5) @(negedge clk_sys);
        hold_i = 1'b1;
        repeat (6) begin
            trak_i[2] = ~trak_i[2];
            @(negedge clk_sys);
            if (x_cnt_o !== CNT_W'(2)) hold_bad = 1'b1;
        end
        repeat (5) begin
            @(negedge clk_sys);
            if (x_cnt_o !== CNT_W'(2)) hold_bad = 1'b1;
        end
        checks++;
        if (hold_bad) begin
            errors++;
            $display("FAIL hold_frozen: got %0d want 2", x_cnt_o);
        end
        hold_i = 1'b0;
        @(negedge clk_sys);
        checks++;
        if (x_cnt_o !== CNT_W'(8)) begin
            errors++;
            $display("FAIL hold_release: got %0d want 8", x_cnt_o);
        end
        trak_i[2] = ~trak_i[2];
        repeat (2) @(negedge clk_sys);
        clr_i = 1'b1;
        @(negedge clk_sys);
        clr_i = 1'b0;
        checks++;
        if (x_step_o !== 1'b0) begin
            errors++;
            $display("FAIL clr_step: x_step=%b want 0", x_step_o);
        end
        @(negedge clk_sys);
        checks++;
        if (x_cnt_o !== '0 || x_dir_o !== 1'b1 || obs !== expv()) begin
            errors++;
            $display("FAIL clr_count: x=%0d dir=%b want 0 1 (obs %h model %h)",
                     x_cnt_o, x_dir_o, obs, expv());
        end
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        trak_i[3] = 1'b1;
        @(negedge clk_sys);
        repeat (7) begin
            trak_i[2] = ~trak_i[2];
            @(negedge clk_sys);
        end
        repeat (5) @(negedge clk_sys);
        checks++;
        if (x_cnt_o !== CNT_W'(7)) begin
            errors++;
            $display("FAIL pre_reset_count: got %0d want 7", x_cnt_o);
        end
        trak_i[2] = ~trak_i[2];
        @(negedge clk_sys);
        trak_i[2] = ~trak_i[2];
        @(negedge clk_sys);
        trak_i = 4'b1100;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL async_reset: got %h want 0", obs);
        end
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk_sys);
            if (j == 3 || j == 4 || j == 10) begin
                checks++;
                if (x_cnt_o !== ((j < 4) ? CNT_W'(0) : CNT_W'(1))) begin
                    errors++;
                    $display("FAIL release_high j=%0d: got %0d", j, x_cnt_o);
                end
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk_sys);
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL random cycle %0d: got %h want %h", c, obs, expv());
            end
            trak_i[2] = trak_i[2] ^ ($urandom_range(0, 1) == 1);
            trak_i[0] = trak_i[0] ^ ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 5) == 0) trak_i[3] = ~trak_i[3];
            if ($urandom_range(0, 5) == 0) trak_i[1] = ~trak_i[1];
            if ($urandom_range(0, 30) == 0) flip_i = ~flip_i;
            if ($urandom_range(0, 7) == 0) hold_i = ~hold_i;
            clr_i = ($urandom_range(0, 24) == 0);
        end
        hold_i = 0; clr_i = 0;
        repeat (6) @(negedge clk_sys);
        checks++;
        if (obs !== expv()) begin
            errors++;
            $display("FAIL random_drain: got %h want %h", obs, expv());
        end
    endtask

    initial begin
        test_reset();
        test_x_up();
        test_y_wrap();
        test_flip_dual();
        test_hold_clr();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
